// File: rtl/melody_player_if.sv
// Melody player bus: transport controls, note-table read port and status outputs.
// Note-table read timing: the player drives note_addr from a register, and
// note_hp/note_dur/note_last must describe that address one cycle later
// (synchronous ROM). This bus has no valid/ready handshake; the player simply
// takes the table data in its LOAD state, which always follows FETCH by one cycle.
interface melody_player_if #(
  parameter int ADDR_W = 5,
  parameter int HP_W   = 16,
  parameter int DUR_W  = 8,
  parameter int LED_N  = 6
);
  logic              play;
  logic              stop;
  logic              loop;
  logic [ADDR_W-1:0] note_addr;
  logic [HP_W-1:0]   note_hp;
  logic [DUR_W-1:0]  note_dur;
  logic              note_last;
  logic              sound;
  logic [LED_N-1:0]  led;
  logic              busy;
  logic              done;
  logic [2:0]        state_dbg;

  // Player side.
  modport master (
    input  play, stop, loop, note_hp, note_dur, note_last,
    output note_addr, sound, led, busy, done, state_dbg
  );

  // Controller / note-table side.
  modport slave (
    output play, stop, loop, note_hp, note_dur, note_last,
    input  note_addr, sound, led, busy, done, state_dbg
  );
endinterface

// File: rtl/melody_player.sv
// Melody player: walks a note table, plays each note as a square wave for
// dur tempo ticks, inserts a silent gap between notes, optionally loops.
// FSM state is exported on bus.state_dbg (IDLE=0 FETCH=1 LOAD=2 PLAY=3 GAP=4).
module melody_player #(
  parameter int ADDR_W   = 5,
  parameter int HP_W     = 16,
  parameter int DUR_W    = 8,
  parameter int TICK_DIV = 250000,
  parameter int GAP_CYC  = 1000,
  parameter int LED_N    = 6
) (
  input  logic             clk,
  input  logic             rst,
  melody_player_if.master  bus
);

  // Counter widths sized so TICK_DIV and GAP_CYC fit (GAP_W stays >= 1 when GAP_CYC=0).
  localparam int TICK_W = $clog2(TICK_DIV + 1);
  localparam int GAP_W  = $clog2(GAP_CYC + 2);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
  localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_LOAD  = 3'd2,
    S_PLAY  = 3'd3,
    S_GAP   = 3'd4
  } state_t;

  state_t            state, nxt;
  logic              play_q, armed, play_rise;
  logic [HP_W-1:0]   hp_r, hp_cnt;
  logic [DUR_W-1:0]  dur_r, dur_cnt;
  logic              last_r;
  logic [TICK_W-1:0] tick_cnt;
  logic [GAP_W-1:0]  gap_cnt;
  logic              play_end, gap_end, note_end, advance, hp_hit;
  logic [ADDR_W-1:0] addr_d;
  logic [LED_N-1:0]  led_d;
  logic              done_d, sound_d;

  // armed is only set once play has been seen low, so a play level held
  // through reset release cannot look like a fresh start request.
  assign play_rise = bus.play & ~play_q & armed;
  assign play_end  = (tick_cnt == TICK_LAST) && (dur_cnt == dur_r - 1'b1);
  assign gap_end   = (gap_cnt == GAP_LAST);
  assign hp_hit    = (hp_r != '0) && (hp_cnt == hp_r - 1'b1);
  assign advance   = !last_r && (bus.note_addr != '1);
  assign note_end  = (GAP_CYC == 0) ? (state == S_PLAY && play_end)
                                    : (state == S_GAP && gap_end);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= nxt;
  end

  // Next-state logic; stop overrides everything, including a start in IDLE.
  always_comb begin
    nxt = state;
    if (bus.stop) begin
      nxt = S_IDLE;
    end else begin
      case (state)
        S_IDLE:  if (play_rise) nxt = S_FETCH;
        S_FETCH: nxt = S_LOAD;
        S_LOAD:  nxt = S_PLAY;
        S_PLAY:  if (play_end) begin
                   if (GAP_CYC > 0)                nxt = S_GAP;
                   else if (advance || bus.loop)   nxt = S_FETCH;
                   else                            nxt = S_IDLE;
                 end
        S_GAP:   if (gap_end) nxt = (advance || bus.loop) ? S_FETCH : S_IDLE;
        default: nxt = S_IDLE;
      endcase
    end
  end

  // Output logic: status plus next values for the registered outputs.
  always_comb begin
    bus.busy      = (state != S_IDLE);
    bus.state_dbg = state;
    addr_d        = bus.note_addr;
    done_d        = 1'b0;
    sound_d       = bus.sound;
    if (bus.stop) begin
      addr_d = '0;
    end else if (state == S_IDLE && play_rise) begin
      addr_d = '0;
    end else if (note_end) begin
      if (advance) begin
        addr_d = bus.note_addr + 1'b1;
      end else begin
        addr_d = '0;
        done_d = !bus.loop;
      end
    end
    if (nxt != S_PLAY)                   sound_d = 1'b0;
    else if (state == S_PLAY && hp_hit)  sound_d = ~bus.sound;
    led_d = (nxt == S_IDLE) ? '0 : (LED_N'(1) << (int'(addr_d) % LED_N));
  end

  // Registered outputs and play edge detector.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      play_q        <= 1'b0;
      armed         <= 1'b0;
      bus.note_addr <= '0;
      bus.sound     <= 1'b0;
      bus.led       <= '0;
      bus.done      <= 1'b0;
    end else begin
      play_q        <= bus.play;
      if (!bus.play) armed <= 1'b1;
      bus.note_addr <= addr_d;
      bus.sound     <= sound_d;
      bus.led       <= led_d;
      bus.done      <= done_d;
    end
  end

  // Latch the addressed note in LOAD; a zero duration plays as one tick.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hp_r   <= '0;
      dur_r  <= '0;
      last_r <= 1'b0;
    end else if (state == S_LOAD) begin
      hp_r   <= bus.note_hp;
      dur_r  <= (bus.note_dur == '0) ? DUR_W'(1) : bus.note_dur;
      last_r <= bus.note_last;
    end
  end

  // Tick, duration and half-period counters run only in PLAY and restart at zero on entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tick_cnt <= '0;
      dur_cnt  <= '0;
      hp_cnt   <= '0;
    end else if (state == S_PLAY) begin
      if (tick_cnt == TICK_LAST) begin
        tick_cnt <= '0;
        dur_cnt  <= dur_cnt + 1'b1;
      end else begin
        tick_cnt <= tick_cnt + 1'b1;
      end
      if (hp_r != '0) hp_cnt <= hp_hit ? '0 : hp_cnt + 1'b1;
    end else begin
      tick_cnt <= '0;
      dur_cnt  <= '0;
      hp_cnt   <= '0;
    end
  end

  // Gap counter runs only in GAP.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                 gap_cnt <= '0;
    else if (state == S_GAP) gap_cnt <= gap_cnt + 1'b1;
    else                     gap_cnt <= '0;
  end

endmodule
